dual_lane_serializer: RTL

Upstream feeder for the two-input test block. Accepts parallel words over a valid/ready handshake and serializes each word onto two 1-bit lanes, driving the block's `in1` and `in2` one bit per clock. A one-word holding register decouples the producer from the shifter, so back-to-back words stream with no idle cycle between them.

---
 rtl/dual_lane_serializer_pkg.sv | 19 +
 rtl/dual_lane_serializer_ser_lane.sv | 33 +++
 rtl/dual_lane_serializer.sv | 104 ++++++++++
 3 files changed

// File: rtl/dual_lane_serializer_pkg.sv
// rtl/dual_lane_serializer_pkg.sv - shared state encoding and sizing helpers for the dual lane serializer
package dual_lane_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Bits per lane for a given word width
  function automatic int half_of(input int width);
    return width / 2;
  endfunction

  // Bit counter width: clog2 of the lane length, never narrower than one bit
  function automatic int cnt_width_of(input int width);
    return ($clog2(width / 2) < 1) ? 1 : $clog2(width / 2);
  endfunction

endpackage

// File: rtl/dual_lane_serializer_ser_lane.sv
// rtl/dual_lane_serializer_ser_lane.sv - one parallel-load shift register with head-bit output
module ser_lane #(
  parameter int HALF      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic [HALF-1:0] load_data,
  output logic            head
);

  logic [HALF-1:0] sr;

  // Parallel load wins over shift; the vacated end fills with zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr <= {sr[HALF-2:0], 1'b0};
      end else begin
        sr <= {1'b0, sr[HALF-1:1]};
      end
    end
  end

  assign head = MSB_FIRST ? sr[HALF-1] : sr[0];

endmodule

// File: rtl/dual_lane_serializer.sv
// rtl/dual_lane_serializer.sv - serializes parallel words onto two 1-bit lanes with a one-word holding register
module dual_lane_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             lane_a,
  output logic             lane_b,
  output logic             lane_valid,
  output logic             frame_start,
  output logic             busy
);

  import dual_lane_serializer_pkg::*;

  localparam int HALF = half_of(WIDTH);
  localparam int CW   = cnt_width_of(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  ser_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic             accept;
  logic             last;
  logic             can_load;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] load_word;
  logic             head_a;
  logic             head_b;

  // Handshake and load/shift decisions; in_ready depends only on hold_full
  always_comb begin
    in_ready  = !hold_full;
    accept    = in_valid && !hold_full;
    last      = (state == ST_SHIFT) && (cnt == CNT_LAST);
    can_load  = (state == ST_IDLE) || last;
    load      = can_load && (hold_full || accept);
    shift     = (state == ST_SHIFT) && !last;
    load_word = hold_full ? hold : in_data;
  end

  // FSM, bit counter and holding register; lanes keep shifting while a word is parked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (can_load && hold_full) begin
      state     <= ST_SHIFT;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else if (can_load && accept) begin
      state <= ST_SHIFT;
      cnt   <= '0;
    end else begin
      if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      if (last) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (state == ST_SHIFT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  ser_lane #(.HALF(HALF), .MSB_FIRST(MSB_FIRST)) u_lane_a (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (load_word[WIDTH-1:HALF]),
    .head      (head_a)
  );

  ser_lane #(.HALF(HALF), .MSB_FIRST(MSB_FIRST)) u_lane_b (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (load_word[HALF-1:0]),
    .head      (head_b)
  );

  // Lane outputs are forced low outside SHIFT so idle lanes read as zero
  always_comb begin
    lane_valid  = (state == ST_SHIFT);
    lane_a      = lane_valid && head_a;
    lane_b      = lane_valid && head_b;
    frame_start = lane_valid && (cnt == '0);
    busy        = lane_valid || hold_full;
  end

endmodule
